invader_fleet: RTL and testbench

Owns the 50-invader formation: position, alive mask, marching motion and shot-versus-invader hit detection. Sits directly upstream of `color_mapper` and drives its `InvaderX`, `InvaderY` and `InvaderOn` inputs. It also consumes the same `ShotX/ShotY/ShotW/ShotH/ShotOn` values that `color_mapper` draws. Work runs once per frame, triggered by a one-cycle frame tick.

---
 rtl/invader_pkg.sv | 53 +++++
 rtl/invader_hit_test.sv | 45 ++++
 rtl/invader_fleet.sv | 260 ++++++++++++++++++++++++++
 tb/tb_invader_fleet.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : invader_pkg
//  Purpose  : Shared geometry constants, FSM state encoding and index helpers
//             for the 50-invader formation.
//  Revision : 1.0  initial release
// ============================================================================
package invader_pkg;

  // Default formation geometry
  localparam int c_fleet_cols        = 10;
  localparam int c_fleet_rows        = 5;
  localparam int c_fleet_col_pitch   = 32;
  localparam int c_fleet_row_pitch   = 24;
  localparam int c_fleet_step_x      = 4;
  localparam int c_fleet_step_y      = 8;
  localparam int c_fleet_left_bound  = 140;
  localparam int c_fleet_right_bound = 500;
  localparam int c_fleet_start_x     = 170;
  localparam int c_fleet_start_y     = 60;
  localparam int c_fleet_land_y      = 440;

  // Largest half-size of any row; wall and landing tests use this margin
  localparam int c_max_half = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EDGE = 2'd2,
    MOVE = 2'd3
  } fleet_state_t;

  // Half-size of an invader sprite by formation row
  function automatic logic [3:0] row_size(input logic [2:0] row);
    case (row)
      3'd0:       return 4'd8;
      3'd1, 3'd2: return 4'd9;
      default:    return 4'd10;
    endcase
  endfunction

  // Row of a linear invader index (index = row*cols + col)
  function automatic logic [2:0] idx_row(input logic [5:0] idx, input int cols);
    return 3'(int'(idx) / cols);
  endfunction

  // Column of a linear invader index
  function automatic logic [3:0] idx_col(input logic [5:0] idx, input int cols);
    return 4'(int'(idx) % cols);
  endfunction

endpackage
`default_nettype wire

// File: rtl/invader_hit_test.sv
`default_nettype none
// ============================================================================
//  Module   : invader_hit_test
//  Purpose  : Combinational overlap test between the shot box and one
//             invader box. Terms are rearranged so no subtraction can wrap.
//  Revision : 1.0  initial release
// ============================================================================
module invader_hit_test (
  input  logic [9:0] i_inv_x,
  input  logic [9:0] i_inv_y,
  input  logic [3:0] i_half_size,
  input  logic       i_alive,
  input  logic [9:0] i_shot_x,
  input  logic [9:0] i_shot_y,
  input  logic [9:0] i_shot_w,
  input  logic [9:0] i_shot_h,
  input  logic       i_shot_on,
  output logic       o_hit
);

  // Widened copies; the sums below never exceed 12 bits
  logic [11:0] w_ix, w_iy, w_s, w_sx, w_sy, w_sw, w_sh;
  logic        w_left_ok, w_right_ok, w_top_ok, w_bot_ok;

  assign w_ix = {2'b00, i_inv_x};
  assign w_iy = {2'b00, i_inv_y};
  assign w_s  = {8'd0, i_half_size};
  assign w_sx = {2'b00, i_shot_x};
  assign w_sy = {2'b00, i_shot_y};
  assign w_sw = {2'b00, i_shot_w};
  assign w_sh = {2'b00, i_shot_h};

  // ShotX >= X - s
  assign w_left_ok  = (w_sx + w_s) >= w_ix;
  // ShotX - ShotW <= X + s
  assign w_right_ok = w_sx <= (w_ix + w_s + w_sw);
  // ShotY + ShotH >= Y - s
  assign w_bot_ok   = (w_sy + w_sh + w_s) >= w_iy;
  // ShotY - ShotH <= Y + s
  assign w_top_ok   = w_sy <= (w_iy + w_s + w_sh);

  assign o_hit = i_alive & i_shot_on & w_left_ok & w_right_ok & w_bot_ok & w_top_ok;

endmodule
`default_nettype wire

// File: rtl/invader_fleet.sv
`default_nettype none
// ============================================================================
//  Module   : invader_fleet
//  Purpose  : Formation state (origin, alive mask, direction), once-per-frame
//             sequential hit scan and marching motion for the invader fleet.
//  Revision : 1.0  initial release
// ============================================================================
module invader_fleet
  import invader_pkg::*;
#(
  parameter int COLS        = c_fleet_cols,
  parameter int ROWS        = c_fleet_rows,
  parameter int COL_PITCH   = c_fleet_col_pitch,
  parameter int ROW_PITCH   = c_fleet_row_pitch,
  parameter int STEP_X      = c_fleet_step_x,
  parameter int STEP_Y      = c_fleet_step_y,
  parameter int LEFT_BOUND  = c_fleet_left_bound,
  parameter int RIGHT_BOUND = c_fleet_right_bound,
  parameter int START_X     = c_fleet_start_x,
  parameter int START_Y     = c_fleet_start_y,
  parameter int LAND_Y      = c_fleet_land_y
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic                 Restart,
  input  logic [9:0]           ShotX,
  input  logic [9:0]           ShotY,
  input  logic [9:0]           ShotW,
  input  logic [9:0]           ShotH,
  input  logic                 ShotOn,
  output logic [9:0]           InvaderX [COLS*ROWS],
  output logic [9:0]           InvaderY [COLS*ROWS],
  output logic [COLS*ROWS-1:0] InvaderOn,
  output logic                 ShotHit,
  output logic [5:0]           HitIndex,
  output logic                 FleetCleared,
  output logic                 FleetLanded
);

  localparam int         c_num_inv  = COLS * ROWS;
  localparam logic [5:0] c_last_idx = 6'(c_num_inv - 1);

  fleet_state_t         r_state, w_state_next;
  logic [9:0]           r_origin_x, r_origin_y;
  logic [c_num_inv-1:0] r_alive;
  logic                 r_dir;          // 0 = marching right
  logic [3:0]           r_frame_cnt;
  logic [5:0]           r_scan_idx;
  logic                 r_shot_hit;
  logic [5:0]           r_hit_index;
  logic                 r_landed;
  logic [3:0]           r_left_col, r_right_col;
  logic [2:0]           r_low_row;

  // Reset and Restart share one reload path and beat every other update
  logic w_reload;
  assign w_reload = !Reset_n || Restart;

  logic w_fleet_empty;
  assign w_fleet_empty = (r_alive == '0);

  // ---------------------------------------------------------------------------
  // Invader centres derived from the origin
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < c_num_inv; gi++) begin : g_pos
    localparam int c_col_idx = gi % COLS;
    localparam int c_row_idx = gi / COLS;
    assign InvaderX[gi] = r_origin_x + 10'(c_col_idx * COL_PITCH);
    assign InvaderY[gi] = r_origin_y + 10'(c_row_idx * ROW_PITCH);
  end

  // ---------------------------------------------------------------------------
  // Single shared hit tester, pointed at the current scan index
  // ---------------------------------------------------------------------------
  logic [2:0] w_scan_row;
  logic [3:0] w_scan_col;
  logic [9:0] w_scan_x, w_scan_y;
  logic       w_hit_raw, w_scan_hit;

  assign w_scan_row = idx_row(r_scan_idx, COLS);
  assign w_scan_col = idx_col(r_scan_idx, COLS);
  assign w_scan_x   = r_origin_x + 10'(int'(w_scan_col) * COL_PITCH);
  assign w_scan_y   = r_origin_y + 10'(int'(w_scan_row) * ROW_PITCH);

  invader_hit_test u_hit_test (
    .i_inv_x     (w_scan_x),
    .i_inv_y     (w_scan_y),
    .i_half_size (row_size(w_scan_row)),
    .i_alive     (r_alive[r_scan_idx]),
    .i_shot_x    (ShotX),
    .i_shot_y    (ShotY),
    .i_shot_w    (ShotW),
    .i_shot_h    (ShotH),
    .i_shot_on   (ShotOn),
    .o_hit       (w_hit_raw)
  );

  assign w_scan_hit = (r_state == SCAN) && w_hit_raw;

  // ---------------------------------------------------------------------------
  // Fleet extents: leftmost/rightmost alive column and lowest alive row
  // ---------------------------------------------------------------------------
  logic [COLS-1:0] w_col_alive;
  logic [ROWS-1:0] w_row_alive;
  logic [3:0]      w_left_col, w_right_col;
  logic [2:0]      w_low_row;

  // Collapse the alive mask into per-column and per-row occupancy, then extents
  always_comb begin
    w_col_alive = '0;
    w_row_alive = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_alive[r*COLS + c]) begin
          w_col_alive[c] = 1'b1;
          w_row_alive[r] = 1'b1;
        end
      end
    end
    w_left_col  = '0;
    w_right_col = '0;
    w_low_row   = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (w_col_alive[c]) w_left_col = 4'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (w_col_alive[c]) w_right_col = 4'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (w_row_alive[r]) w_low_row = 3'(r);
    end
  end

  // ---------------------------------------------------------------------------
  // March timing: fewer survivors means a shorter step period
  // ---------------------------------------------------------------------------
  logic [5:0] w_alive_count;
  logic [3:0] w_period;

  // Population count of the alive mask
  always_comb begin
    w_alive_count = '0;
    for (int i = 0; i < c_num_inv; i++) begin
      w_alive_count = w_alive_count + {5'd0, r_alive[i]};
    end
  end

  assign w_period = 4'(1 + int'(w_alive_count) / 5);

  // ---------------------------------------------------------------------------
  // Wall and landing tests, using the extents latched in EDGE
  // ---------------------------------------------------------------------------
  logic        w_step_wait;
  logic [11:0] w_right_edge, w_left_edge, w_land_line;
  logic        w_at_wall;
  logic [9:0]  w_drop_y, w_next_y;
  logic        w_land;

  assign w_step_wait  = ({1'b0, r_frame_cnt} + 5'd1) < {1'b0, w_period};
  assign w_right_edge = {2'b00, r_origin_x} + 12'(int'(r_right_col) * COL_PITCH)
                      + 12'(c_max_half + STEP_X);
  assign w_left_edge  = {2'b00, r_origin_x} + 12'(int'(r_left_col) * COL_PITCH);
  assign w_at_wall    = r_dir ? (w_left_edge < 12'(LEFT_BOUND + c_max_half + STEP_X))
                              : (w_right_edge > 12'(RIGHT_BOUND));
  assign w_drop_y     = r_origin_y + 10'(STEP_Y);
  assign w_next_y     = (!w_step_wait && w_at_wall) ? w_drop_y : r_origin_y;
  assign w_land_line  = {2'b00, w_next_y} + 12'(int'(r_low_row) * ROW_PITCH)
                      + 12'(c_max_half);
  assign w_land       = w_land_line >= 12'(LAND_Y);

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------

  // Next-state: start a frame only from IDLE with a live, unlanded fleet
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (frame_tick && !w_fleet_empty && !r_landed) w_state_next = SCAN;
      SCAN:    if (w_scan_hit || (r_scan_idx == c_last_idx)) w_state_next = EDGE;
      EDGE:    w_state_next = MOVE;
      MOVE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (w_reload) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Formation datapath: scan index, kills, extents latch and marching step
  always_ff @(posedge Clk) begin
    if (w_reload) begin
      r_origin_x  <= 10'(START_X);
      r_origin_y  <= 10'(START_Y);
      r_alive     <= '1;
      r_dir       <= 1'b0;
      r_frame_cnt <= '0;
      r_scan_idx  <= '0;
      r_shot_hit  <= 1'b0;
      r_hit_index <= '0;
      r_landed    <= 1'b0;
      r_left_col  <= '0;
      r_right_col <= '0;
      r_low_row   <= '0;
    end else begin
      r_shot_hit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_state_next == SCAN) r_scan_idx <= '0;
        end
        SCAN: begin
          if (w_scan_hit) begin
            r_alive[r_scan_idx] <= 1'b0;
            r_shot_hit          <= 1'b1;
            r_hit_index         <= r_scan_idx;
          end else begin
            r_scan_idx <= r_scan_idx + 6'd1;
          end
        end
        EDGE: begin
          r_left_col  <= w_left_col;
          r_right_col <= w_right_col;
          r_low_row   <= w_low_row;
        end
        MOVE: begin
          // An empty fleet stays frozen where the last kill left it
          if (!w_fleet_empty) begin
            if (w_step_wait) begin
              r_frame_cnt <= r_frame_cnt + 4'd1;
            end else begin
              r_frame_cnt <= '0;
              if (w_at_wall) begin
                r_origin_y <= w_drop_y;
                r_dir      <= ~r_dir;
              end else if (r_dir) begin
                r_origin_x <= r_origin_x - 10'(STEP_X);
              end else begin
                r_origin_x <= r_origin_x + 10'(STEP_X);
              end
            end
            if (w_land) r_landed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign InvaderOn    = r_alive;
  assign ShotHit      = r_shot_hit;
  assign HitIndex     = r_hit_index;
  assign FleetCleared = w_fleet_empty;
  assign FleetLanded  = r_landed;

endmodule
`default_nettype wire

// File: tb/tb_invader_fleet.sv
`default_nettype none
// ============================================================================
//  Module   : tb_invader_fleet
//  Purpose  : Self-checking bench for invader_fleet: table vectors, directed
//             march/clear/landing/reset sequences and randomized frames
//             against a behavioural formation model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_invader_fleet;

  localparam int c_n = 50;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       Restart = 1'b0;
  logic [9:0] ShotX = '0, ShotY = '0, ShotW = '0, ShotH = '0;
  logic       ShotOn = 1'b0;
  logic [9:0] InvaderX [c_n];
  logic [9:0] InvaderY [c_n];
  logic [c_n-1:0] InvaderOn;
  logic       ShotHit;
  logic [5:0] HitIndex;
  logic       FleetCleared, FleetLanded;

  int total = 0;
  int bad   = 0;

  invader_fleet dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .Restart      (Restart),
    .ShotX        (ShotX),
    .ShotY        (ShotY),
    .ShotW        (ShotW),
    .ShotH        (ShotH),
    .ShotOn       (ShotOn),
    .InvaderX     (InvaderX),
    .InvaderY     (InvaderY),
    .InvaderOn    (InvaderOn),
    .ShotHit      (ShotHit),
    .HitIndex     (HitIndex),
    .FleetCleared (FleetCleared),
    .FleetLanded  (FleetLanded)
  );

  always #5 Clk = ~Clk;

  // Behavioural model of the formation
  int             m_ox, m_oy, m_dir, m_cnt, m_hit_idx;
  bit             m_landed;
  logic [c_n-1:0] m_mask;
  int             last_hit;

  typedef struct {
    int sx; int sy; int sw; int sh;
    bit son; bit exp_hit; int exp_idx;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge Clk);
    #1;
  endtask

  function automatic int half_of(input int row);
    return (row == 0) ? 8 : ((row < 3) ? 9 : 10);
  endfunction

  task automatic model_reset();
    m_ox = 170; m_oy = 60; m_dir = 0; m_cnt = 0; m_hit_idx = 0;
    m_landed = 1'b0; m_mask = '1;
  endtask

  task automatic model_frame(input int sx, input int sy, input int sw, input int sh,
                             input bit son, output int hit);
    int x, y, s, alive_n, lc, rc, lr, period;
    hit = -1;
    if (m_mask == '0 || m_landed) return;
    if (son) begin
      for (int i = 0; i < c_n; i++) begin
        if (m_mask[i]) begin
          x = (m_ox + (i % 10) * 32) % 1024;
          y = (m_oy + (i / 10) * 24) % 1024;
          s = half_of(i / 10);
          if (sx >= x - s && sx - sw <= x + s && sy + sh >= y - s && sy - sh <= y + s) begin
            hit = i;
            break;
          end
        end
      end
    end
    if (hit >= 0) begin
      m_mask[hit] = 1'b0;
      m_hit_idx   = hit;
    end
    if (m_mask == '0) return;
    alive_n = 0; lc = 99; rc = -1; lr = -1;
    for (int i = 0; i < c_n; i++) begin
      if (m_mask[i]) begin
        alive_n++;
        if (i % 10 < lc) lc = i % 10;
        if (i % 10 > rc) rc = i % 10;
        if (i / 10 > lr) lr = i / 10;
      end
    end
    period = 1 + alive_n / 5;
    if (m_cnt + 1 < period) begin
      m_cnt++;
    end else begin
      m_cnt = 0;
      if ((m_dir == 0 && m_ox + rc * 32 + 14 > 500) || (m_dir == 1 && m_ox + lc * 32 < 154)) begin
        m_oy  = (m_oy + 8) % 1024;
        m_dir = 1 - m_dir;
      end else if (m_dir == 0) begin
        m_ox = (m_ox + 4) % 1024;
      end else begin
        m_ox = (m_ox + 1020) % 1024;
      end
    end
    if (m_oy + lr * 24 + 10 >= 440) m_landed = 1'b1;
  endtask

  // One frame: tick, let the DUT finish, then compare with the model
  task automatic do_frame(input int sx, input int sy, input int sw, input int sh,
                          input bit son, input bit extra);
    int pulses, hit, j;
    ShotX = 10'(sx); ShotY = 10'(sy); ShotW = 10'(sw); ShotH = 10'(sh); ShotOn = son;
    frame_tick = 1'b1;
    step_clk();
    frame_tick = 1'b0;
    pulses = 0;
    for (int k = 0; k < 56; k++) begin
      frame_tick = extra && !son && (k == 5);
      if (ShotHit) pulses++;
      step_clk();
    end
    frame_tick = 1'b0;
    model_frame(sx, sy, sw, sh, son, hit);
    last_hit = hit;
    chk("hit_pulses", 64'(pulses), (hit >= 0) ? 64'd1 : 64'd0);
    chk("hit_index", 64'(HitIndex), 64'(m_hit_idx));
    chk("alive_mask", 64'(InvaderOn), 64'(m_mask));
    chk("origin_x", 64'(InvaderX[0]), 64'(m_ox));
    chk("origin_y", 64'(InvaderY[0]), 64'(m_oy));
    chk("cleared", 64'(FleetCleared), 64'(m_mask == '0));
    chk("landed", 64'(FleetLanded), 64'(m_landed));
    j = $urandom_range(0, c_n - 1);
    chk("pos_x", 64'(InvaderX[j]), 64'((m_ox + (j % 10) * 32) % 1024));
    chk("pos_y", 64'(InvaderY[j]), 64'((m_oy + (j / 10) * 24) % 1024));
  endtask

  task automatic shoot(input int j);
    do_frame((m_ox + (j % 10) * 32) % 1024 + 2, (m_oy + (j / 10) * 24) % 1024, 4, 4, 1'b1, 1'b0);
  endtask

  task automatic do_restart();
    Restart = 1'b1;
    step_clk();
    Restart = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x0"}, 64'(InvaderX[0]), 64'd170);
    chk({tag, "_y0"}, 64'(InvaderY[0]), 64'd60);
    chk({tag, "_x49"}, 64'(InvaderX[49]), 64'd458);
    chk({tag, "_y49"}, 64'(InvaderY[49]), 64'd156);
    chk({tag, "_mask"}, 64'(InvaderOn), 64'h3_FFFF_FFFF_FFFF);
    chk({tag, "_shothit"}, 64'(ShotHit), 64'd0);
    chk({tag, "_hitidx"}, 64'(HitIndex), 64'd0);
    chk({tag, "_cleared"}, 64'(FleetCleared), 64'd0);
    chk({tag, "_landed"}, 64'(FleetLanded), 64'd0);
  endtask

  initial begin
    logic [c_n-1:0] em;
    int sav_x, sav_y, r;

    vecs[0] = '{268, 108, 4, 4, 1'b1, 1'b1, 23};
    vecs[1] = '{266, 72, 4, 4, 1'b1, 1'b1, 3};
    vecs[2] = '{268, 108, 4, 4, 1'b0, 1'b0, 0};
    vecs[3] = '{600, 300, 4, 4, 1'b1, 1'b0, 0};
    vecs[4] = '{162, 60, 0, 0, 1'b1, 1'b1, 0};
    vecs[5] = '{161, 60, 0, 0, 1'b1, 1'b0, 0};
    vecs[6] = '{458, 146, 0, 0, 1'b1, 1'b1, 49};
    vecs[7] = '{480, 156, 12, 0, 1'b1, 1'b1, 49};
    vecs[8] = '{480, 156, 11, 0, 1'b1, 1'b0, 0};

    // Power-on reset
    model_reset();
    step_clk();
    step_clk();
    Reset_n = 1'b1;
    check_reset_vals("reset");

    // Eleven quiet frames: first step happens on the 11th
    for (int f = 1; f <= 11; f++) begin
      do_frame(0, 0, 0, 0, 1'b0, 1'b0);
      if (f == 10) chk("x_after_10", 64'(InvaderX[0]), 64'd170);
    end
    chk("x_after_11", 64'(InvaderX[0]), 64'd174);

    // Table vectors, each from a freshly restarted formation
    for (int v = 0; v < 9; v++) begin
      do_restart();
      do_frame(vecs[v].sx, vecs[v].sy, vecs[v].sw, vecs[v].sh, vecs[v].son, 1'b0);
      em = '1;
      if (vecs[v].exp_hit) em[vecs[v].exp_idx] = 1'b0;
      chk("tbl_mask", 64'(InvaderOn), 64'(em));
      chk("tbl_idx", 64'(HitIndex), vecs[v].exp_hit ? 64'(vecs[v].exp_idx) : 64'd0);
    end

    // Full fleet marches to the right wall and drops
    do_restart();
    for (int f = 0; f < 200 && m_dir == 0; f++) do_frame(0, 0, 0, 0, 1'b0, 1'b0);
    chk("wall_x", 64'(InvaderX[0]), 64'd202);
    chk("wall_y", 64'(InvaderY[0]), 64'd68);

    // Without column 9 the wall is reached further right
    do_restart();
    for (int rr = 0; rr < 5; rr++) shoot(rr * 10 + 9);
    for (int f = 0; f < 300 && m_dir == 0; f++) do_frame(0, 0, 0, 0, 1'b0, 1'b0);
    chk("wall8_x", 64'(InvaderX[0]), 64'd234);
    chk("wall8_y", 64'(InvaderY[0]), 64'd68);

    // Randomized frames, including ignored mid-frame ticks
    do_restart();
    for (int f = 0; f < 150; f++) begin
      r = int'($urandom_range(0, 9));
      if (r < 1) begin
        do_restart();
      end else if (r < 5) begin
        shoot(int'($urandom_range(0, c_n - 1)));
      end else begin
        do_frame(int'($urandom_range(120, 520)), int'($urandom_range(40, 460)),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                 1'($urandom_range(0, 1)), 1'b1);
      end
    end

    // Clear the whole fleet, then confirm it is frozen
    do_restart();
    for (int j = 0; j < c_n; j++) shoot(j);
    chk("all_cleared", 64'(FleetCleared), 64'd1);
    sav_x = int'(InvaderX[0]);
    sav_y = int'(InvaderY[0]);
    do_frame(0, 0, 0, 0, 1'b0, 1'b0);
    chk("clr_frozen_x", 64'(InvaderX[0]), 64'(sav_x));
    chk("clr_frozen_y", 64'(InvaderY[0]), 64'(sav_y));
    do_restart();
    check_reset_vals("restart");

    // Two survivors in the bottom row march down to the landing line
    do_restart();
    for (int j = 0; j < c_n; j++) if (j != 40 && j != 49) shoot(j);
    for (int f = 0; f < 700 && !m_landed; f++) do_frame(0, 0, 0, 0, 1'b0, 1'b0);
    chk("landed_set", 64'(FleetLanded), 64'd1);
    sav_x = int'(InvaderX[0]);
    sav_y = int'(InvaderY[0]);
    do_frame(0, 0, 0, 0, 1'b0, 1'b0);
    chk("land_frozen_x", 64'(InvaderX[0]), 64'(sav_x));
    chk("land_frozen_y", 64'(InvaderY[0]), 64'(sav_y));

    // Reset from the landed state
    Reset_n = 1'b0;
    step_clk();
    check_reset_vals("land_reset");
    Reset_n = 1'b1;
    model_reset();

    // Reset in the middle of a scan that would otherwise kill invader 45
    ShotX = 10'(170 + 5 * 32 + 2); ShotY = 10'(60 + 4 * 24); ShotW = 10'd4; ShotH = 10'd4;
    ShotOn = 1'b1;
    frame_tick = 1'b1;
    step_clk();
    frame_tick = 1'b0;
    for (int k = 0; k < 20; k++) step_clk();
    Reset_n = 1'b0;
    step_clk();
    check_reset_vals("scan_reset");
    Reset_n = 1'b1;
    ShotOn = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (ShotHit) chk("late_hit", 64'(ShotHit), 64'd0);
      step_clk();
    end
    model_reset();
    do_frame(0, 0, 0, 0, 1'b0, 1'b0);
    shoot(45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
